// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the multiplexed BCD display block.
//   NUM_DIGITS   number of display positions (history depth)
//   IDX_W        width of the scan index
//   SEG_*        segment patterns, bit order {dp,g,f,e,d,c,b,a}, active-high
//   bcd_t        one 4-bit digit as delivered by the upstream BCD counter
//   is_bcd()     true for digits 0..9
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef logic [3:0] bcd_t;

    function automatic logic is_bcd(input bcd_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Purely combinational BCD to 7-segment decoder. Codes 10..15 are shown as a
// dash so a corrupt digit is visible on the display. The decimal point is
// never lit.
//   bcd_in   [3:0]  digit to show
//   seg_out  [7:0]  segments {dp,g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module seg7_decode
    import bcd_pkg::*;
(
    input  logic [3:0] bcd_in,
    output logic [7:0] seg_out
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives seg_out;
        // a missing assignment on any path would infer a latch.
        seg_out = SEG_DASH;
        case (bcd_in)
            4'd0:    seg_out = SEG_0;
            4'd1:    seg_out = SEG_1;
            4'd2:    seg_out = SEG_2;
            4'd3:    seg_out = SEG_3;
            4'd4:    seg_out = SEG_4;
            4'd5:    seg_out = SEG_5;
            4'd6:    seg_out = SEG_6;
            4'd7:    seg_out = SEG_7;
            4'd8:    seg_out = SEG_8;
            4'd9:    seg_out = SEG_9;
            default: seg_out = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
// Captures a stream of BCD digits into a 4-deep history and drives a
// time-multiplexed 4-digit 7-segment display from it. hist[0] is the newest
// digit (rightmost position), hist[3] the oldest and most significant.
// A prescaler holds each position for SCAN_DIV clocks. Optional leading-zero
// blanking suppresses zeros on positions 3..1 above the first non-zero digit.
// A sticky error flag records any captured non-BCD digit.
//   clk          clock, all state on rising edge
//   rst_syn      asynchronous active-high reset
//   digit_in     incoming digit
//   digit_valid  capture strobe for digit_in
//   hold         1 = ignore digit_valid, freeze history (scan keeps running)
//   blank_en     1 = leading-zero blanking on
//   err_clr      clears err (a simultaneous non-BCD capture wins)
//   seg_out      segments {dp,g,f,e,d,c,b,a} of the current position
//   an_out       one-hot position enable, 1 << idx
//   err          sticky non-BCD capture flag
// -----------------------------------------------------------------------------
module bcd_scan_display
    import bcd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4   // clocks per position, 1..255
) (
    input  logic                  clk,
    input  logic                  rst_syn,
    input  logic [3:0]            digit_in,
    input  logic                  digit_valid,
    input  logic                  hold,
    input  logic                  blank_en,
    input  logic                  err_clr,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic                  err
);

    localparam int              PRESC_W    = 8;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

    // Packed so the capture shift is a single concatenation; slice 0 is newest.
    logic [NUM_DIGITS-1:0][3:0] hist_q, hist_d;
    logic [PRESC_W-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       err_q, err_d;

    logic capture;
    logic presc_wrap;

    assign capture    = digit_valid & ~hold;
    assign presc_wrap = (presc_q == PRESC_LAST);

    // ---------------- next-state ----------------
    always_comb begin
        hist_d  = hist_q;
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        err_d   = err_q;

        // With SCAN_DIV=1 the prescaler sits at 0 and wraps every edge.
        if (presc_wrap) begin
            presc_d = '0;
            idx_d   = idx_q + 1'b1;
        end

        if (capture) begin
            hist_d = {hist_q[NUM_DIGITS-2:0], digit_in};
        end

        // Set has priority over clear.
        if (capture && !is_bcd(digit_in)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // ---------------- state register ----------------
    // NOTE: the 4-entry history is a handful of flops, not a RAM, so it is
    // cleared by reset together with the rest of the state; a real memory
    // array would be left out of the reset branch.
    always_ff @(posedge clk or posedge rst_syn) begin
        if (rst_syn) begin
            hist_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            hist_q  <= hist_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // ---------------- display path ----------------
    // zero_run[k] = hist[k] and every more significant entry are zero.
    logic [NUM_DIGITS-1:0] zero_run;

    always_comb begin
        zero_run = '0;
        zero_run[NUM_DIGITS-1] = (hist_q[NUM_DIGITS-1] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            zero_run[k] = (hist_q[k] == 4'd0) && zero_run[k+1];
        end
    end

    logic [3:0] cur_digit;
    logic [7:0] seg_raw;
    logic       blank_pos;

    assign cur_digit = hist_q[idx_q];

    seg7_decode u_seg7_decode (
        .bcd_in  (cur_digit),
        .seg_out (seg_raw)
    );

    // Position 0 is never blanked so a value of zero still shows one digit.
    assign blank_pos = blank_en && (idx_q != '0) && zero_run[idx_q];
    assign seg_out   = blank_pos ? SEG_BLANK : seg_raw;
    assign an_out    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
// Two instances share all inputs: SCAN_DIV=4 (default) and SCAN_DIV=1.
// Expected values come from hand-written constants and from a behavioural
// model holding the history as an int array and deriving the scan position
// arithmetically from the number of edges since reset.
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst_syn;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       hold;
    logic       blank_en;
    logic       err_clr;

    logic [7:0] seg4, seg1;
    logic [3:0] an4, an1;
    logic       err4, err1;

    always #5 clk = ~clk;

    bcd_scan_display #(.SCAN_DIV(4)) dut4 (
        .clk         (clk),
        .rst_syn     (rst_syn),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .hold        (hold),
        .blank_en    (blank_en),
        .err_clr     (err_clr),
        .seg_out     (seg4),
        .an_out      (an4),
        .err         (err4)
    );

    bcd_scan_display #(.SCAN_DIV(1)) dut1 (
        .clk         (clk),
        .rst_syn     (rst_syn),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .hold        (hold),
        .blank_en    (blank_en),
        .err_clr     (err_clr),
        .seg_out     (seg1),
        .an_out      (an1),
        .err         (err1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] seg_tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    int m_hist [4];
    bit m_err;
    int m_edges;

    function automatic logic [7:0] ref_display(input int pos);
        bit all_zero = 1'b1;
        for (int j = pos; j < 4; j++) if (m_hist[j] != 0) all_zero = 1'b0;
        if (blank_en && pos > 0 && all_zero) return 8'h00;
        if (m_hist[pos] > 9) return 8'h40;
        return seg_tbl[m_hist[pos]];
    endfunction

    task automatic model_edge();
        bit cap;
        if (rst_syn) begin
            m_hist  = '{default: 0};
            m_err   = 1'b0;
            m_edges = 0;
        end else begin
            cap = digit_valid && !hold;
            if (cap) begin
                for (int j = 3; j > 0; j--) m_hist[j] = m_hist[j-1];
                m_hist[0] = int'(digit_in);
            end
            if (cap && digit_in > 4'd9) m_err = 1'b1;
            else if (err_clr)           m_err = 1'b0;
            m_edges++;
        end
    endtask

    task automatic check_model(input string tag);
        int i4 = (m_edges / 4) % 4;
        int i1 = m_edges % 4;
        check({tag, " an4"},  {4'b0, an4},  8'(1 << i4));
        check({tag, " seg4"}, seg4,         ref_display(i4));
        check({tag, " err4"}, {7'b0, err4}, {7'b0, m_err});
        check({tag, " an1"},  {4'b0, an1},  8'(1 << i1));
        check({tag, " seg1"}, seg1,         ref_display(i1));
        check({tag, " err1"}, {7'b0, err1}, {7'b0, m_err});
    endtask

    // One clock: model follows the edge, outputs are sampled 1 unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic set_in(input logic v, input logic [3:0] d, input logic h,
                          input logic b, input logic c);
        digit_valid = v;
        digit_in    = d;
        hold        = h;
        blank_en    = b;
        err_clr     = c;
    endtask

    task automatic do_reset(input logic b);
        set_in(1'b0, 4'd0, 1'b0, b, 1'b0);
        rst_syn = 1'b1;
        step("rst");
        step("rst");
        rst_syn = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0] d;
        logic       h;
        logic       b;
        logic [7:0] exp_seg;
        logic       exp_err;
    } vec_t;

    vec_t tbl [18];

    logic [3:0] exp_an_seq [4];
    logic [7:0] e;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'd0,  1'b0, 1'b0, 8'h3F, 1'b0};
        tbl[1]  = '{4'd1,  1'b0, 1'b1, 8'h06, 1'b0};
        tbl[2]  = '{4'd2,  1'b0, 1'b0, 8'h5B, 1'b0};
        tbl[3]  = '{4'd3,  1'b0, 1'b1, 8'h4F, 1'b0};
        tbl[4]  = '{4'd4,  1'b0, 1'b0, 8'h66, 1'b0};
        tbl[5]  = '{4'd5,  1'b0, 1'b1, 8'h6D, 1'b0};
        tbl[6]  = '{4'd6,  1'b0, 1'b0, 8'h7D, 1'b0};
        tbl[7]  = '{4'd7,  1'b0, 1'b1, 8'h07, 1'b0};
        tbl[8]  = '{4'd8,  1'b0, 1'b0, 8'h7F, 1'b0};
        tbl[9]  = '{4'd9,  1'b0, 1'b1, 8'h6F, 1'b0};
        tbl[10] = '{4'd10, 1'b0, 1'b0, 8'h40, 1'b1};
        tbl[11] = '{4'd11, 1'b0, 1'b1, 8'h40, 1'b1};
        tbl[12] = '{4'd12, 1'b0, 1'b0, 8'h40, 1'b1};
        tbl[13] = '{4'd13, 1'b0, 1'b1, 8'h40, 1'b1};
        tbl[14] = '{4'd14, 1'b0, 1'b0, 8'h40, 1'b1};
        tbl[15] = '{4'd15, 1'b0, 1'b1, 8'h40, 1'b1};
        tbl[16] = '{4'd9,  1'b1, 1'b0, 8'h3F, 1'b0};
        tbl[17] = '{4'd12, 1'b1, 1'b1, 8'h3F, 1'b0};

        exp_an_seq[0] = 4'b0010;
        exp_an_seq[1] = 4'b0100;
        exp_an_seq[2] = 4'b1000;
        exp_an_seq[3] = 4'b0001;

        rst_syn = 1'b0;
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        m_hist  = '{default: 0};
        m_err   = 1'b0;
        m_edges = 0;

        // Reset values, then the 4-clock scan stepping.
        set_in(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        rst_syn = 1'b1;
        step("rst");
        step("rst");
        check("rst an", {4'b0, an4}, 8'h01);
        check("rst seg", seg4, 8'h3F);
        check("rst err", {7'b0, err4}, 8'h00);
        rst_syn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) step("scan");
            check("scan an", {4'b0, an4}, {4'b0, exp_an_seq[i]});
        end

        // Single-capture decode table, checked at position 0.
        for (int i = 0; i < 18; i++) begin
            do_reset(tbl[i].b);
            set_in(1'b1, tbl[i].d, tbl[i].h, tbl[i].b, 1'b0);
            step("tbl");
            check($sformatf("tbl%0d an", i), {4'b0, an4}, 8'h01);
            check($sformatf("tbl%0d seg", i), seg4, tbl[i].exp_seg);
            check($sformatf("tbl%0d err", i), {7'b0, err4}, {7'b0, tbl[i].exp_err});
        end

        // Capture 2,3,4,5 then scan the four positions.
        do_reset(1'b0);
        for (int d = 2; d <= 5; d++) begin
            set_in(1'b1, 4'(d), 1'b0, 1'b0, 1'b0);
            step("cap");
        end
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step("capscan");
            case (an4)
                4'b0001: e = 8'h6D;
                4'b0010: e = 8'h66;
                4'b0100: e = 8'h4F;
                default: e = 8'h5B;
            endcase
            check("capscan seg", seg4, e);
        end

        // Leading-zero blanking on a single 7, then off again.
        do_reset(1'b1);
        set_in(1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        step("blank");
        set_in(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step("blank");
            check("blank on seg", seg4, (an4 == 4'b0001) ? 8'h07 : 8'h00);
        end
        blank_en = 1'b0;
        #1;
        check("blank off immediate", seg4, (an4 == 4'b0001) ? 8'h07 : 8'h3F);
        for (int i = 0; i < 16; i++) begin
            step("noblank");
            check("blank off seg", seg4, (an4 == 4'b0001) ? 8'h07 : 8'h3F);
        end

        // Sticky error: set, set wins over clear, clear alone.
        do_reset(1'b0);
        set_in(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        step("err");
        check("err set", {7'b0, err4}, 8'h01);
        check("err dash", seg4, 8'h40);
        set_in(1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
        step("err");
        check("err set wins", {7'b0, err4}, 8'h01);
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step("err");
        check("err cleared", {7'b0, err4}, 8'h00);
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Hold freezes the history while scanning continues.
        do_reset(1'b0);
        set_in(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step("hold");
        check("hold pos0", seg4, (an4 == 4'b0001) ? 8'h3F : 8'h3F);
        check("hold scans", {4'b0, an4}, 8'h01);
        set_in(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        step("unhold");
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step("unhold");
            check("unhold seg", seg4, (an4 == 4'b0001) ? 8'h6F : 8'h3F);
        end

        // Asynchronous reset between edges while scanning (SCAN_DIV=1 too).
        do_reset(1'b1);
        set_in(1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
        step("areset");
        set_in(1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
        step("areset");
        step("areset");
        #2;
        rst_syn = 1'b1;
        #1;
        check("areset an1", {4'b0, an1}, 8'h01);
        check("areset seg1", seg1, 8'h3F);
        check("areset err1", {7'b0, err1}, 8'h00);
        check("areset an4", {4'b0, an4}, 8'h01);
        check("areset seg4", seg4, 8'h3F);
        step("areset");
        rst_syn = 1'b0;
        set_in(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step("areset");
        check("areset restart an1", {4'b0, an1}, 8'h02);

        // Randomized traffic against the model.
        for (int i = 0; i < 1000; i++) begin
            set_in($urandom_range(1, 0) == 1, 4'($urandom_range(15, 0)),
                   $urandom_range(4, 0) == 0, $urandom_range(1, 0) == 1,
                   $urandom_range(9, 0) == 0);
            if (i > 2 && $urandom_range(79, 0) == 0) begin
                rst_syn = 1'b1;
                step("rnd");
                rst_syn = 1'b0;
            end
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
